rng_arbiter: RTL and testbench

//  Shares one random_gen instance among NUM_REQ requesters (game logic, sprite spawner, etc).

---
 rtl/rng_arbiter.sv | 130 +++++++++++++
 tb/tb_rng_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rng_arbiter.sv
// Round-robin arbiter sharing one random_gen among NUM_REQ requesters.
// Drives the granted range to the generator, waits for it to settle, and returns one sample with an ack pulse.
module rng_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int SETTLE  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_min,
  input  logic [NUM_REQ*WIDTH-1:0] req_max,
  output logic [NUM_REQ-1:0]       ack,
  output logic [WIDTH-1:0]         rand_out,
  output logic                     range_err,
  output logic                     busy,
  output logic [WIDTH-1:0]         rng_min,
  output logic [WIDTH-1:0]         rng_max,
  input  logic [WIDTH-1:0]         rng_sample
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [IW:0] NREQ = (IW+1)'(NUM_REQ);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, ACK} state_t;

  state_t           state, state_next;
  logic [IW-1:0]    last_grant, grant_idx, pick_idx;
  logic [IW:0]      cand;
  logic             pick_valid;
  logic [WIDTH-1:0] pick_min, pick_max, lat_min, lat_max;
  logic [CW-1:0]    wait_cnt;
  logic             wait_done;

  // Scan from farthest to nearest so the requester closest after last_grant wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = {1'b0, last_grant} + (IW+1)'(k);
      if (cand >= NREQ) cand = cand - NREQ;
      if (req[cand[IW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    pick_min = '0;
    pick_max = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IW'(i)) begin
        pick_min = req_min[i*WIDTH +: WIDTH];
        pick_max = req_max[i*WIDTH +: WIDTH];
      end
    end
  end

  assign wait_done = (wait_cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_valid) state_next = LOAD;
      LOAD:    state_next = WAIT;
      WAIT:    if (wait_done) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A full [0, all-ones] range is narrowed by one because random_gen's modulus would wrap to 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ack        <= '0;
      rand_out   <= '0;
      range_err  <= 1'b0;
      busy       <= 1'b0;
      rng_min    <= '0;
      rng_max    <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      grant_idx  <= '0;
      lat_min    <= '0;
      lat_max    <= '0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_idx  <= pick_idx;
            last_grant <= pick_idx;
            lat_min    <= pick_min;
            lat_max    <= pick_max;
            rng_min    <= pick_min;
            rng_max    <= (pick_min == '0 && pick_max == '1) ? {{(WIDTH-1){1'b1}}, 1'b0} : pick_max;
            busy       <= 1'b1;
          end
        end
        LOAD: wait_cnt <= CW'(SETTLE);
        WAIT: begin
          wait_cnt <= wait_cnt - CW'(1);
          if (wait_done) begin
            ack <= NUM_REQ'(1) << grant_idx;
            if (lat_max < lat_min) begin
              rand_out  <= lat_min;
              range_err <= 1'b1;
            end else begin
              rand_out  <= rng_sample;
              range_err <= 1'b0;
            end
          end
        end
        ACK: begin
          ack  <= '0;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rng_arbiter.sv
// Self-checking bench for rng_arbiter: behavioural random_gen stand-in, a timing-level
// reference model compared every cycle, and directed plus randomized scenarios.
module tb_rng_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int S = 1;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_min = '0;
  logic [N*W-1:0] req_max = '0;
  logic [N-1:0]   ack;
  logic [W-1:0]   rand_out;
  logic           range_err;
  logic           busy;
  logic [W-1:0]   rng_min;
  logic [W-1:0]   rng_max;
  logic [W-1:0]   rng_sample = '0;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  rng_arbiter #(.NUM_REQ(N), .WIDTH(W), .SETTLE(S)) dut (
    .clk(clk), .reset(reset), .req(req), .req_min(req_min), .req_max(req_max),
    .ack(ack), .rand_out(rand_out), .range_err(range_err), .busy(busy),
    .rng_min(rng_min), .rng_max(rng_max), .rng_sample(rng_sample)
  );

  // Stand-in for random_gen: registered sample drawn uniformly from the currently driven range.
  always @(posedge clk) begin
    if (rng_max >= rng_min)
      rng_sample <= rng_min + W'($urandom % (32'(rng_max) - 32'(rng_min) + 32'd1));
    else
      rng_sample <= W'($urandom);
  end

  // Reference model: a grant at edge n acks at edge n+1+S and frees the arbiter at edge n+S+3.
  int           cyc = 0;
  bit           m_active = 1'b0;
  int           m_ack_edge = 0;
  int           m_last = N - 1;
  int           m_idx = 0;
  int           m_pick;
  logic [W-1:0] m_lo = '0, m_hi = '0, m_eff_hi = '0;
  logic [N-1:0] e_ack = '0;
  logic         e_busy = 1'b0, e_err = 1'b0;
  logic [W-1:0] e_rand = '0, e_min = '0, e_max = '0;

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      m_active = 1'b0;
      m_last   = N - 1;
      e_ack    = '0;
      e_busy   = 1'b0;
      e_err    = 1'b0;
      e_rand   = '0;
      e_min    = '0;
      e_max    = '0;
    end else if (!m_active) begin
      m_pick = -1;
      for (int k = 1; k <= N; k++)
        if (m_pick < 0 && req[(m_last + k) % N]) m_pick = (m_last + k) % N;
      if (m_pick >= 0) begin
        m_idx      = m_pick;
        m_last     = m_pick;
        m_lo       = req_min[m_idx*W +: W];
        m_hi       = req_max[m_idx*W +: W];
        m_eff_hi   = (m_lo == 0 && m_hi == {W{1'b1}}) ? W'((1 << W) - 2) : m_hi;
        e_min      = m_lo;
        e_max      = m_eff_hi;
        e_busy     = 1'b1;
        m_ack_edge = cyc + 1 + S;
        m_active   = 1'b1;
      end
    end else if (cyc == m_ack_edge) begin
      e_ack = N'(1) << m_idx;
      if (m_hi < m_lo) begin
        e_rand = m_lo;
        e_err  = 1'b1;
      end else begin
        e_rand = rng_sample;
        e_err  = 1'b0;
      end
    end else if (cyc == m_ack_edge + 1) begin
      e_ack    = '0;
      e_busy   = 1'b0;
      m_active = 1'b0;
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_output("ack", 32'(ack), 32'(e_ack));
      check_output("busy", 32'(busy), 32'(e_busy));
      check_output("rand_out", 32'(rand_out), 32'(e_rand));
      check_output("range_err", 32'(range_err), 32'(e_err));
      check_output("rng_min", 32'(rng_min), 32'(e_min));
      check_output("rng_max", 32'(rng_max), 32'(e_max));
      if (e_ack != '0 && !e_err)
        check_output("rand_in_range", 32'(rand_out >= m_lo && rand_out <= m_eff_hi), 32'd1);
    end
  end

  // Raise one request, wait (bounded) for its ack, then drop it and let the arbiter return to idle.
  task automatic apply_stimulus(input int idx, input logic [W-1:0] lo, input logic [W-1:0] hi,
                                output logic [W-1:0] got, output logic err, output int lat);
    logic [N-1:0] seen;
    req_min[idx*W +: W] = lo;
    req_max[idx*W +: W] = hi;
    req[idx] = 1'b1;
    lat = 0;
    seen = '0;
    got = '0;
    err = 1'b0;
    for (int t = 1; t <= 20 && lat == 0; t++) begin
      @(negedge clk);
      if (ack != '0) begin
        lat  = t;
        seen = ack;
        got  = rand_out;
        err  = range_err;
      end
    end
    req[idx] = 1'b0;
    check_output("ack_onehot", 32'(seen), 32'(N'(1) << idx));
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] got, lo, hi;
    logic         err;
    int           lat, n, mode, alt_err, prev, n_acks, cur;
    int           order[5];
    int           when[5];
    logic [15:0]  cov;

    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check_output("reset_ack", 32'(ack), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_rng_max", 32'(rng_max), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Case 1: basic serve with two-edge latency
    apply_stimulus(0, 8'd10, 8'd20, got, err, lat);
    check_output("t1_latency", 32'(lat), 32'd3);
    check_output("t1_in_range", 32'(got >= 8'd10 && got <= 8'd20), 32'd1);
    check_output("t1_range_err", 32'(err), 32'd0);

    // Case 3: inverted range returns min with range_err
    apply_stimulus(2, 8'd50, 8'd40, got, err, lat);
    check_output("t3_latency", 32'(lat), 32'd3);
    check_output("t3_rand_out", 32'(got), 32'd50);
    check_output("t3_range_err", 32'(err), 32'd1);

    // Case 4: degenerate and full ranges
    apply_stimulus(1, 8'd7, 8'd7, got, err, lat);
    check_output("t4_equal_rand", 32'(got), 32'd7);
    check_output("t4_equal_err", 32'(err), 32'd0);
    apply_stimulus(3, 8'd0, 8'd255, got, err, lat);
    check_output("t4_full_rng_max", 32'(rng_max), 32'd254);
    check_output("t4_full_le_254", 32'(got <= 8'd254), 32'd1);
    check_output("t4_full_no_x", 32'(^got === 1'bx), 32'd0);
    check_output("t4_full_err", 32'(err), 32'd0);

    // Case 2: all requesting after reset -> 0,1,2,3,0 with 4-cycle spacing
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_min[i*W +: W] = W'(i * 40);
      req_max[i*W +: W] = W'(i * 40 + 30);
    end
    for (int j = 0; j < 5; j++) begin
      order[j] = -1;
      when[j] = 0;
    end
    req = '1;
    n = 0;
    for (int t = 0; t < 60 && n < 5; t++) begin
      @(negedge clk);
      if (ack != '0) begin
        for (int i = 0; i < N; i++) if (ack[i]) order[n] = i;
        when[n] = cyc;
        n++;
      end
    end
    req = '0;
    check_output("t2_ack_count", 32'(n), 32'd5);
    for (int j = 0; j < 5; j++) begin
      check_output("t2_order", 32'(order[j]), 32'(j % N));
      if (j > 0) check_output("t2_spacing", 32'(when[j] - when[j-1]), 32'(S + 3));
    end
    repeat (2) @(negedge clk);

    // Case 5: reset in WAIT aborts, then normal serve
    req_min[1*W +: W] = 8'd30;
    req_max[1*W +: W] = 8'd40;
    req[1] = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    req = '0;
    @(negedge clk);
    check_output("t5_ack", 32'(ack), 32'd0);
    check_output("t5_busy", 32'(busy), 32'd0);
    check_output("t5_rand_out", 32'(rand_out), 32'd0);
    check_output("t5_rng_min", 32'(rng_min), 32'd0);
    reset = 1'b1;
    apply_stimulus(1, 8'd30, 8'd40, got, err, lat);
    check_output("t5_latency", 32'(lat), 32'd3);
    check_output("t5_in_range", 32'(got >= 8'd30 && got <= 8'd40), 32'd1);

    // Case 6: two held requesters alternate; requester 3 range churns every cycle
    req_min[1*W +: W] = 8'd0;
    req_max[1*W +: W] = 8'd15;
    req = 4'b1010;
    alt_err = 0;
    prev = -1;
    n_acks = 0;
    cov = '0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      req_min[3*W +: W] = W'($urandom);
      req_max[3*W +: W] = W'($urandom);
      if (ack != '0) begin
        cur = -1;
        for (int i = 0; i < N; i++) if (ack[i]) cur = i;
        if (cur != 1 && cur != 3) alt_err++;
        if (cur == prev) alt_err++;
        if (cur == 1) cov[rand_out[3:0]] = 1'b1;
        prev = cur;
        n_acks++;
      end
    end
    req = '0;
    check_output("t6_alternation", 32'(alt_err), 32'd0);
    check_output("t6_ack_count", 32'(n_acks >= 240), 32'd1);
    check_output("t6_coverage", 32'($countones(cov) >= 8), 32'd1);
    repeat (2) @(negedge clk);

    // Randomized requesters with level handshake, mixed range kinds and rare resets
    for (int t = 0; t < 800; t++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 149) != 0);
      for (int i = 0; i < N; i++) begin
        if (req[i] && ack[i]) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          mode = $urandom_range(0, 5);
          lo = W'($urandom);
          case (mode)
            0: hi = lo;
            1: begin
              if (lo == '0) lo = 8'd1;
              hi = W'($urandom_range(0, 32'(lo) - 1));
            end
            2: begin
              lo = '0;
              hi = '1;
            end
            default: hi = (lo > 8'd239) ? 8'hFF : lo + W'($urandom_range(0, 15));
          endcase
          req_min[i*W +: W] = lo;
          req_max[i*W +: W] = hi;
          req[i] = 1'b1;
        end
      end
    end
    reset = 1'b1;
    req = '0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
